fifo_rd_stream: RTL and testbench
=================================

Name: fifo_rd_stream

Overview:
Read-side engine for the team's 8-entry FIFO. It owns the read pointer and compares it with the write pointer supplied by the write-side controller. It issues read addresses to the synchronous FIFO memory and presents the returned words downstream as a valid/ready stream. A 2-entry output buffer sustains one word per cycle under backpressure without losing data. The read pointer is returned to the write side for full detection.

Parameters:
DATA_W, 8, width of a FIFO word
ADDR_W, 3, memory address width; DEPTH = 2**ADDR_W (8); pointers are ADDR_W+1 bits with a wrap bit

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
wr_ptr  in  ADDR_W+1  write pointer from write-side controller, same clock domain, wrap bit in MSB
rd_ptr  out  ADDR_W+1  registered read pointer, returned to write side
level  out  ADDR_W+1  wr_ptr - rd_ptr (mod 2**(ADDR_W+1)), range 0..DEPTH
empty  out  1  wr_ptr == rd_ptr
mem_rd_en  out  1  read strobe to FIFO memory
mem_rd_addr  out  ADDR_W  rd_ptr[ADDR_W-1:0]
mem_rd_data  in  DATA_W  memory read data, valid the cycle after mem_rd_en (registered read)
m_valid  out  1  output word available
m_ready  in  1  downstream accepts
m_data  out  DATA_W  head-of-buffer word

Behaviour:
- Reset (rst=1 at edge): rd_ptr=0, inflight=0, buf_cnt=0, both buffer slots=0, m_valid=0, m_data=0. mem_rd_en is forced to 0 while rst=1. level and empty follow wr_ptr combinationally.
- empty = (wr_ptr == rd_ptr). Full (level==DEPTH) occurs when the pointers differ only in the MSB. This state is legal and is handled like any nonzero level.
- pop = m_valid && m_ready.
- inflight is a 1-bit register equal to the previous cycle's mem_rd_en.
- Issue rule: mem_rd_en = !rst && !empty && (buf_cnt + inflight - pop < 2).
- On issue: rd_ptr <= rd_ptr + 1, with natural wrap mod 2**(ADDR_W+1). Address 7 is followed by address 0, and the MSB toggles.
- Capture: when inflight=1, mem_rd_data is written into the buffer that cycle. With both capture and pop in the same cycle, the head slot is refilled in order and buf_cnt is unchanged.
- Buffer: 2-entry in-order queue (head, tail). buf_cnt is 0..2 and never exceeds 2; the issue rule guarantees this. m_valid = (buf_cnt != 0) and m_data = head, both registered.
- Latency: if wr_ptr != rd_ptr in cycle t with buffer space available, mem_rd_en is high in t, data is captured at the end of t+1, and m_valid is high in t+2.
- Throughput: with m_ready held high and level >= 1 continuously, one word per cycle is delivered after the initial 2-cycle latency.
- Backpressure: with m_ready=0, at most 2 words are fetched (buffer plus in-flight). After that mem_rd_en stays 0 and rd_ptr holds. m_data is stable while m_valid=1 and m_ready=0.
- Simultaneous write-side update: wr_ptr changing in the same cycle as an issue is handled next cycle. This block only reads wr_ptr.
- Reset mid-operation: the in-flight read and the buffer contents are discarded, with no m_valid pulse after reset. The write side is reset in the same cycle by system convention.
- Data ordering: words leave in exactly the order of memory addresses issued. No word is duplicated or dropped.

Test Plan:
1. Assert rst for 2 cycles with wr_ptr=0 -> rd_ptr=0, m_valid=0, mem_rd_en=0, empty=1, level=0.
2. Change wr_ptr 0->1 with memory[0]=0xA5 and m_ready=1 -> mem_rd_en=1 with addr 0 in cycle t; m_valid=1 and m_data=0xA5 in t+2 for exactly one cycle; rd_ptr=1; empty=1.
3. Fill 8 words (0x10..0x17) so wr_ptr=8 (4'b1000) -> level=8, empty=0. Drain with m_ready=1 -> 8 consecutive valid cycles, data 0x10..0x17, final rd_ptr=8.
4. Fill 4 words, hold m_ready=0 for 6 cycles -> exactly 2 mem_rd_en pulses, rd_ptr=2, m_data holds the first word. Release m_ready -> all 4 words arrive in order.
5. Stream 20 words through with the writer staying ahead and random m_ready -> rd_ptr wraps (15->0), all 20 words are in order with no loss or duplicate, and buf_cnt never exceeds 2.
6. Assert rst for 1 cycle while m_valid=1 and a read is in flight -> next cycle m_valid=0, rd_ptr=0, and the stale mem_rd_data is not captured.

Source files
------------

// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_stream
// Purpose  : Read-side engine for the 8-entry FIFO. Owns the read pointer,
//            issues reads to the registered-output FIFO memory and presents
//            the returned words as a valid/ready stream through a 2-entry
//            in-order output buffer.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_stream #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W:0]   wr_ptr,
    output logic [ADDR_W:0]   rd_ptr,
    output logic [ADDR_W:0]   level,
    output logic              empty,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data
);

    // Two buffer slots; a read may only be launched if the word it returns
    // is guaranteed a slot once it arrives.
    localparam logic [2:0] c_BUF_SLOTS = 3'd2;

    logic [ADDR_W:0]   r_rd_ptr;
    logic              r_inflight;
    logic [1:0]        r_buf_cnt;
    logic [DATA_W-1:0] r_head;
    logic [DATA_W-1:0] r_tail;
    logic              r_m_valid;

    logic              w_empty;
    logic              w_pop;
    logic [2:0]        w_occ;
    logic              w_issue;
    logic [1:0]        w_cnt_nxt;
    logic [DATA_W-1:0] w_head_nxt;
    logic [DATA_W-1:0] w_tail_nxt;

    // Pointer comparison: the wrap bit distinguishes full from empty.
    assign w_empty = (wr_ptr == r_rd_ptr);
    assign w_pop   = r_m_valid & m_ready;

    // Words already committed to the buffer (held or in flight) after this
    // cycle's pop. A pop implies buf_cnt >= 1, so this never underflows.
    assign w_occ   = {1'b0, r_buf_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue = ~rst & ~w_empty & (w_occ < c_BUF_SLOTS);

    // Next-state of the in-order output queue for every capture/pop combination.
    always_comb begin
        w_cnt_nxt  = r_buf_cnt;
        w_head_nxt = r_head;
        w_tail_nxt = r_tail;
        unique case ({r_inflight, w_pop})
            2'b01: begin
                w_head_nxt = r_tail;
                w_cnt_nxt  = r_buf_cnt - 2'd1;
            end
            2'b10: begin
                if (r_buf_cnt == 2'd0) begin
                    w_head_nxt = mem_rd_data;
                end else begin
                    w_tail_nxt = mem_rd_data;
                end
                w_cnt_nxt = r_buf_cnt + 2'd1;
            end
            2'b11: begin
                // Head leaves and the new word joins the back; count unchanged.
                if (r_buf_cnt == 2'd1) begin
                    w_head_nxt = mem_rd_data;
                end else begin
                    w_head_nxt = r_tail;
                    w_tail_nxt = mem_rd_data;
                end
            end
            default: begin
            end
        endcase
    end

    // Read pointer, in-flight flag, output queue and registered stream outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr   <= '0;
            r_inflight <= 1'b0;
            r_buf_cnt  <= 2'd0;
            r_head     <= '0;
            r_tail     <= '0;
            r_m_valid  <= 1'b0;
        end else begin
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_inflight <= w_issue;
            r_buf_cnt  <= w_cnt_nxt;
            r_head     <= w_head_nxt;
            r_tail     <= w_tail_nxt;
            r_m_valid  <= (w_cnt_nxt != 2'd0);
        end
    end

    assign rd_ptr      = r_rd_ptr;
    assign level       = wr_ptr - r_rd_ptr;
    assign empty       = w_empty;
    assign mem_rd_en   = w_issue;
    assign mem_rd_addr = r_rd_ptr[ADDR_W-1:0];
    assign m_valid     = r_m_valid;
    assign m_data      = r_head;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_fifo_rd_stream
// Purpose  : Self-checking bench for fifo_rd_stream with a registered-read
//            memory model and a word-order / occupancy reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_stream;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [ADDR_W:0]   level;
    logic              empty;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;

    fifo_rd_stream #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .wr_ptr      (wr_ptr),
        .rd_ptr      (rd_ptr),
        .level       (level),
        .empty       (empty),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data)
    );

    always #5 clk = ~clk;

    // FIFO storage with a registered read port.
    logic [DATA_W-1:0] mem [0:7];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    // Reference model state.
    int               n_checks = 0;
    int               n_pass   = 0;
    int               n_issue  = 0;
    int               n_deliv  = 0;
    logic [7:0]       exp_q [$];
    logic [3:0]       iss_ptr  = 4'd0;   // reads issued since reset
    logic [3:0]       dlv_ptr  = 4'd0;   // words accepted downstream since reset
    logic             prev_en  = 1'b0;   // a read was issued last cycle
    logic             prev_hold = 1'b0;
    logic [7:0]       prev_data = 8'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Per-cycle comparison of the DUT against the reference model.
    task automatic monitor();
        logic       pop;
        logic [3:0] outst;
        logic [3:0] held;
        logic       exp_en;
        logic [7:0] w;
        pop   = (m_valid === 1'b1) && (m_ready === 1'b1);
        outst = iss_ptr - dlv_ptr;
        held  = outst - {3'd0, prev_en};
        if (rst) begin
            chk("rd_en_in_reset", {31'd0, mem_rd_en}, 32'd0);
        end else begin
            chk("rd_ptr", {28'd0, rd_ptr}, {28'd0, iss_ptr});
            chk("level", {28'd0, level}, {28'd0, 4'(wr_ptr - iss_ptr)});
            chk("empty", {31'd0, empty}, {31'd0, (wr_ptr == iss_ptr)});
            chk("m_valid", {31'd0, m_valid}, {31'd0, (held != 4'd0)});
            exp_en = (wr_ptr != iss_ptr) && ((outst - {3'd0, pop}) < 4'd2);
            chk("mem_rd_en", {31'd0, mem_rd_en}, {31'd0, exp_en});
            if (mem_rd_en) chk("mem_rd_addr", {29'd0, mem_rd_addr}, {29'd0, iss_ptr[2:0]});
            chk("outstanding_le2", {31'd0, (outst <= 4'd2)}, 32'd1);
            if (prev_hold) begin
                chk("hold_valid", {31'd0, m_valid}, 32'd1);
                chk("hold_data", {24'd0, m_data}, {24'd0, prev_data});
            end
            if (pop) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_word", {31'd0, m_valid}, 32'd0);
                end else begin
                    w = exp_q.pop_front();
                    chk("data_order", {24'd0, m_data}, {24'd0, w});
                end
            end
        end
        if (mem_rd_en === 1'b1) n_issue++;
        if (rst) begin
            iss_ptr   = 4'd0;
            dlv_ptr   = 4'd0;
            prev_en   = 1'b0;
            prev_hold = 1'b0;
        end else begin
            iss_ptr   = iss_ptr + {3'd0, mem_rd_en};
            dlv_ptr   = dlv_ptr + {3'd0, pop};
            if (pop) n_deliv++;
            prev_en   = mem_rd_en;
            prev_hold = m_valid && !m_ready;
        end
        prev_data = m_data;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic fin();
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        at_neg();
        fin();
    endtask

    task automatic push_word(input logic [7:0] d);
        mem[wr_ptr[2:0]] = d;
        exp_q.push_back(d);
        wr_ptr = wr_ptr + 4'd1;
    endtask

    task automatic do_reset(input int cycles);
        rst     = 1'b1;
        wr_ptr  = 4'd0;
        m_ready = 1'b0;
        exp_q.delete();
        repeat (cycles) cyc();
        rst = 1'b0;
    endtask

    initial begin
        int         first;
        int         last;
        int         nv;
        int         iss0;
        int         written;
        int         dlv0;
        logic       wrapped;
        logic [3:0] prev_rd;

        rst = 1'b1; wr_ptr = 4'd0; m_ready = 1'b0; mem_rd_data = '0;
        for (int i = 0; i < 8; i++) mem[i] = '0;
        @(posedge clk); #1;

        // 1: reset state
        do_reset(2);
        at_neg();
        chk("rst_rd_ptr", {28'd0, rd_ptr}, 32'd0);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_mem_rd_en", {31'd0, mem_rd_en}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_level", {28'd0, level}, 32'd0);
        fin();

        // 2: single word, two-cycle latency, one-cycle valid
        m_ready = 1'b1;
        push_word(8'hA5);
        at_neg();
        chk("t0_rd_en", {31'd0, mem_rd_en}, 32'd1);
        chk("t0_addr", {29'd0, mem_rd_addr}, 32'd0);
        fin();
        at_neg();
        chk("t1_valid", {31'd0, m_valid}, 32'd0);
        fin();
        at_neg();
        chk("t2_valid", {31'd0, m_valid}, 32'd1);
        chk("t2_data", {24'd0, m_data}, 32'h0000_00A5);
        fin();
        at_neg();
        chk("t3_valid", {31'd0, m_valid}, 32'd0);
        chk("t3_rd_ptr", {28'd0, rd_ptr}, 32'd1);
        chk("t3_empty", {31'd0, empty}, 32'd1);
        fin();

        // 3: full FIFO, back-to-back drain
        do_reset(1);
        for (int i = 0; i < 8; i++) push_word(8'(8'h10 + i));
        m_ready = 1'b1;
        first = -1; last = -1; nv = 0;
        for (int i = 0; i < 14; i++) begin
            at_neg();
            if (i == 0) begin
                chk("full_level", {28'd0, level}, 32'd8);
                chk("full_empty", {31'd0, empty}, 32'd0);
            end
            if (m_valid) begin
                if (first < 0) first = i;
                last = i;
                nv++;
            end
            fin();
        end
        chk("drain8_count", nv, 32'd8);
        chk("drain8_back_to_back", last - first, 32'd7);
        chk("drain8_latency", first, 32'd2);
        at_neg();
        chk("drain8_rd_ptr", {28'd0, rd_ptr}, 32'd8);
        fin();

        // 4: backpressure
        do_reset(1);
        for (int i = 0; i < 4; i++) push_word(8'(8'h40 + i));
        iss0 = n_issue;
        repeat (6) cyc();
        chk("bp_pulses", n_issue - iss0, 32'd2);
        at_neg();
        chk("bp_rd_ptr", {28'd0, rd_ptr}, 32'd2);
        chk("bp_valid", {31'd0, m_valid}, 32'd1);
        chk("bp_head", {24'd0, m_data}, 32'h0000_0040);
        fin();
        m_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) cyc();
        chk("bp_all_delivered", exp_q.size(), 32'd0);

        // 5: random stream of 20 words across the pointer wrap
        written = 0; dlv0 = n_deliv; wrapped = 1'b0; prev_rd = rd_ptr;
        for (int i = 0; i < 600 && (n_deliv - dlv0) < 20; i++) begin
            if (written < 20 && (written - (n_deliv - dlv0)) < 8 && $urandom_range(0, 3) != 0) begin
                push_word(8'($urandom));
                written++;
            end
            m_ready = ($urandom_range(0, 3) != 0);
            at_neg();
            if (prev_rd == 4'd15 && rd_ptr == 4'd0) wrapped = 1'b1;
            prev_rd = rd_ptr;
            fin();
        end
        chk("rand_delivered", n_deliv - dlv0, 32'd20);
        chk("rand_queue_empty", exp_q.size(), 32'd0);
        chk("rand_wrapped", {31'd0, wrapped}, 32'd1);
        at_neg();
        chk("rand_rd_ptr", {28'd0, rd_ptr}, 32'd8);
        fin();

        // 6: reset while a word is held and a read is in flight
        do_reset(1);
        for (int i = 0; i < 4; i++) push_word(8'(8'h60 + i));
        cyc();
        cyc();
        rst = 1'b1; wr_ptr = 4'd0; exp_q.delete();
        at_neg();
        chk("pre_rst_valid", {31'd0, m_valid}, 32'd1);
        fin();
        rst = 1'b0;
        at_neg();
        chk("post_rst_valid", {31'd0, m_valid}, 32'd0);
        chk("post_rst_rd_ptr", {28'd0, rd_ptr}, 32'd0);
        fin();
        at_neg();
        chk("no_stale_capture", {31'd0, m_valid}, 32'd0);
        fin();
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
